// File: rtl/mac.sv
// Unsigned multiply-accumulate cell: out accumulates a*b on every enabled edge.
// Define MAC_SATURATE_EN to clamp at all ones on overflow instead of wrapping.
module mac #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic [ACC_WIDTH-1:0] out,
    output logic                 overflow
);
    localparam int PW = A_WIDTH + B_WIDTH;

    generate
        if (ACC_WIDTH < PW) begin : g_width_check
            $error("mac: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
        end
    endgenerate

    logic [PW-1:0]        prod;
    logic [ACC_WIDTH:0]   sum;

    // One extra bit on the adder captures the carry that flags overflow.
    always_comb begin
        prod = PW'(a) * PW'(b);
        sum  = {1'b0, out} + {{(ACC_WIDTH + 1 - PW){1'b0}}, prod};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= '0;
            overflow <= 1'b0;
        end else if (enable) begin
`ifdef MAC_SATURATE_EN
            if (sum[ACC_WIDTH]) begin
                out      <= '1;
                overflow <= 1'b1;
            end else begin
                out <= sum[ACC_WIDTH-1:0];
            end
`else
            out <= sum[ACC_WIDTH-1:0];
            if (sum[ACC_WIDTH])
                overflow <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_mac.sv
// Directed self-checking bench for mac (default 8x8 -> 24-bit configuration).
module tb_mac;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [23:0] out;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    mac #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(24)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .a(a), .b(b), .out(out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drive between edges, apply one rising edge, sample just after it.
    task automatic step(input logic r, input logic e, input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        reset = r; enable = e; a = va; b = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic acc_n(input int n, input logic [7:0] va, input logic [7:0] vb);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, va, vb);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 8'd0, 8'd0);
        checks++;
        if (out !== 24'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%0d ovf=%b expected out=0 ovf=0", out, overflow);
        end
    endtask

    task automatic test_accumulate;
        step(1'b0, 1'b1, 8'd15, 8'd10);
        checks++;
        if (out !== 24'd150) begin
            errors++;
            $display("FAIL acc_first: out=%0d expected 150", out);
        end
        step(1'b0, 1'b1, 8'd25, 8'd20);
        checks++;
        if (out !== 24'd650 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL acc_second: out=%0d ovf=%b expected out=650 ovf=0", out, overflow);
        end
    endtask

    task automatic test_hold;
        step(1'b0, 1'b0, 8'd50, 8'd30);
        checks++;
        if (out !== 24'd650) begin
            errors++;
            $display("FAIL hold: out=%0d expected 650", out);
        end
        step(1'b0, 1'b1, 8'd100, 8'd50);
        checks++;
        if (out !== 24'd5650) begin
            errors++;
            $display("FAIL after_hold: out=%0d expected 5650", out);
        end
    endtask

    task automatic test_zero_operand;
        step(1'b0, 1'b1, 8'd0, 8'd77);
        checks++;
        if (out !== 24'd5650) begin
            errors++;
            $display("FAIL zero_a: out=%0d expected 5650", out);
        end
        step(1'b0, 1'b1, 8'd99, 8'd0);
        checks++;
        if (out !== 24'd5650) begin
            errors++;
            $display("FAIL zero_b: out=%0d expected 5650", out);
        end
    endtask

    task automatic test_midstream_reset;
        step(1'b1, 1'b1, 8'd0, 8'd0);
        checks++;
        if (out !== 24'd0) begin
            errors++;
            $display("FAIL mid_reset: out=%0d expected 0", out);
        end
        step(1'b0, 1'b1, 8'd200, 8'd100);
        checks++;
        if (out !== 24'd20000) begin
            errors++;
            $display("FAIL resume_first: out=%0d expected 20000", out);
        end
        step(1'b0, 1'b1, 8'd255, 8'd200);
        checks++;
        if (out !== 24'd71000) begin
            errors++;
            $display("FAIL resume_second: out=%0d expected 71000", out);
        end
    endtask

    task automatic test_reset_priority;
        step(1'b1, 1'b1, 8'd255, 8'd255);
        checks++;
        if (out !== 24'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: out=%0d ovf=%b expected out=0 ovf=0", out, overflow);
        end
    endtask

    task automatic test_overflow;
        step(1'b1, 1'b0, 8'd0, 8'd0);
        acc_n(258, 8'd255, 8'd255);
        checks++;
        if (out !== 24'd16776450 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre: out=%0d ovf=%b expected out=16776450 ovf=0", out, overflow);
        end
        step(1'b0, 1'b1, 8'd255, 8'd255);
`ifdef MAC_SATURATE_EN
        checks++;
        if (out !== 24'd16777215 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_edge: out=%0d ovf=%b expected out=16777215 ovf=1", out, overflow);
        end
`else
        checks++;
        if (out !== 24'd64259 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_edge: out=%0d ovf=%b expected out=64259 ovf=1", out, overflow);
        end
`endif
        step(1'b0, 1'b0, 8'd1, 8'd1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_hold: ovf=%b expected 1", overflow);
        end
        step(1'b0, 1'b1, 8'd255, 8'd255);
`ifdef MAC_SATURATE_EN
        checks++;
        if (out !== 24'd16777215 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: out=%0d ovf=%b expected out=16777215 ovf=1", out, overflow);
        end
`else
        checks++;
        if (out !== 24'd129284 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: out=%0d ovf=%b expected out=129284 ovf=1", out, overflow);
        end
`endif
        step(1'b1, 1'b0, 8'd0, 8'd0);
        checks++;
        if (out !== 24'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: out=%0d ovf=%b expected out=0 ovf=0", out, overflow);
        end
    endtask

    // Land exactly on 2^24-1 (no overflow), then step one past it.
    task automatic test_exact_max;
        step(1'b1, 1'b0, 8'd0, 8'd0);
        acc_n(258, 8'd255, 8'd255);
        step(1'b0, 1'b1, 8'd255, 8'd3);
        checks++;
        if (out !== 24'd16777215 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL exact_max: out=%0d ovf=%b expected out=16777215 ovf=0", out, overflow);
        end
        step(1'b0, 1'b1, 8'd1, 8'd1);
`ifdef MAC_SATURATE_EN
        checks++;
        if (out !== 24'd16777215 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL max_plus_one: out=%0d ovf=%b expected out=16777215 ovf=1", out, overflow);
        end
`else
        checks++;
        if (out !== 24'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL max_plus_one: out=%0d ovf=%b expected out=0 ovf=1", out, overflow);
        end
`endif
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; a = '0; b = '0;
        test_reset;
        test_accumulate;
        test_hold;
        test_zero_operand;
        test_midstream_reset;
        test_reset_priority;
        test_overflow;
        test_exact_max;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
